// File: rtl/i2c_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C register-init sequencer and its init ROM.
//   state_t          : sequencer state encoding (readback states exist in
//                      every build, they are only reachable when the
//                      I2C_READBACK_EN macro is defined)
//   I2C_WRITE/READ   : values driven on the master's i_wr_en input
//   DEFAULT_ADDR_IC  : default 7-bit slave address
//   isLastEntry      : 9-bit index compare so a 256-entry table ends cleanly
// ----------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT_W,
    ST_GAP,
    ST_ISSUE_R,
    ST_WAIT_R,
    ST_GAP_R,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic I2C_WRITE = 1'b1;
  localparam logic I2C_READ  = 1'b0;

  localparam logic [6:0] DEFAULT_ADDR_IC = 7'h68;

  // Widen the index to 9 bits before comparing against nEntries-1. With 256
  // entries the last index is 255, and the compare must never wrap to 0.
  function automatic logic isLastEntry(input logic [7:0] idx,
                                       input int unsigned nEntries);
    logic [8:0] lastIdx;
    lastIdx = 9'(nEntries - 1);
    return ({1'b0, idx} == lastIdx);
  endfunction

endpackage

// File: rtl/i2c_init_rom.sv
// ----------------------------------------------------------------------------
// i2c_init_rom
// Combinational register-init table placed beside i2c_init_sequencer.
//   i_idx   in  8  table index from the sequencer (o_tbl_idx)
//   o_reg   out 8  register address for that entry
//   o_data  out 8  data byte for that entry
// Indices beyond the populated table read back as zero.
// ----------------------------------------------------------------------------
module i2c_init_rom
  import i2c_pkg::*;
(
  input  logic [7:0] i_idx,
  output logic [7:0] o_reg,
  output logic [7:0] o_data
);

  // Plain lookup table: one (register, data) pair per index.
  always_comb begin
    o_reg  = 8'h00;
    o_data = 8'h00;
    case (i_idx)
      8'd0: begin o_reg = 8'h6B; o_data = 8'h00; end
      8'd1: begin o_reg = 8'h1A; o_data = 8'h03; end
      8'd2: begin o_reg = 8'h1B; o_data = 8'h5A; end
      8'd3: begin o_reg = 8'h1C; o_data = 8'h10; end
      8'd4: begin o_reg = 8'h38; o_data = 8'h01; end
      8'd5: begin o_reg = 8'h19; o_data = 8'h07; end
      8'd6: begin o_reg = 8'h23; o_data = 8'h78; end
      8'd7: begin o_reg = 8'h6C; o_data = 8'h00; end
      default: begin o_reg = 8'h00; o_data = 8'h00; end
    endcase
  end

endmodule

// File: rtl/i2c_init_sequencer.sv
// ----------------------------------------------------------------------------
// i2c_init_sequencer
// Walks a register-init table and issues one I2C write per entry to a fixed
// slave address through the master's i_en_I2C / i_wr_en / o_flag_w handshake.
//
// Parameters: N_ENTRIES (1..256), ADDR_IC, TIMEOUT_CYC, GAP_CYC (>=1)
// Ports:
//   clock_100Khz  in   block clock, shared with the I2C master
//   i_reset       in   synchronous active-high reset
//   i_start       in   start pulse, ignored while busy
//   o_tbl_idx     out  index into the init ROM
//   i_tbl_reg     in   ROM register address at o_tbl_idx
//   i_tbl_data    in   ROM data byte at o_tbl_idx
//   o_addr_ic     out  slave address (constant ADDR_IC)
//   o_addr_reg    out  register address to the master
//   o_data_wr     out  write data to the master
//   o_wr_en       out  1 = write, 0 = read
//   o_en_I2C      out  transaction enable, high for the whole transaction
//   i_flag_w      in   master write-done flag
//   i_flag_r      in   master read-done flag
//   i_data_read   in   master read data
//   o_busy        out  walk in progress
//   o_done        out  sticky walk-complete flag
//   o_error       out  sticky timeout / readback-mismatch flag
//   o_err_idx     out  index of the failing entry while o_error
//
// Build option: define I2C_READBACK_EN to read every register back after it
// is written and flag an error on mismatch. Without it the block is
// write-only.
// ----------------------------------------------------------------------------
module i2c_init_sequencer
  import i2c_pkg::*;
#(
  parameter int unsigned N_ENTRIES   = 8,
  parameter logic [6:0]  ADDR_IC     = DEFAULT_ADDR_IC,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned GAP_CYC     = 4
) (
  input  logic       clock_100Khz,
  input  logic       i_reset,
  input  logic       i_start,
  output logic [7:0] o_tbl_idx,
  input  logic [7:0] i_tbl_reg,
  input  logic [7:0] i_tbl_data,
  output logic [6:0] o_addr_ic,
  output logic [7:0] o_addr_reg,
  output logic [7:0] o_data_wr,
  output logic       o_wr_en,
  output logic       o_en_I2C,
  input  logic       i_flag_w,
  input  logic       i_flag_r,
  input  logic [7:0] i_data_read,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error,
  output logic [7:0] o_err_idx
);

  localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam int GW = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC + 1);

  state_t        state_q;
  logic          enI2c_q;
  logic          wrEn_q;
  logic [7:0]    addrReg_q;
  logic [7:0]    dataWr_q;
  logic [7:0]    tblIdx_q;
  logic          busy_q;
  logic          done_q;
  logic          error_q;
  logic [7:0]    errIdx_q;
  logic [TW-1:0] timeoutCnt_q;
  logic [TW-1:0] timeoutCnt_d;
  logic [GW-1:0] gapCnt_q;
  logic [GW-1:0] gapCnt_d;
  logic          timeoutHit;
  logic          gapHit;
  logic          lastEntry;
  logic          masterIdle;

`ifndef I2C_READBACK_EN
  logic [7:0] unusedDataRead;
  assign unusedDataRead = i_data_read;
`endif

  // Counter increments and their terminal conditions. A counter "hits" on
  // the cycle it would reach its limit, so the waiting state lasts exactly
  // TIMEOUT_CYC (or GAP_CYC) cycles.
  always_comb begin
    timeoutCnt_d = timeoutCnt_q + TW'(1);
    gapCnt_d     = gapCnt_q + GW'(1);
    timeoutHit   = (timeoutCnt_d == TW'(TIMEOUT_CYC));
    gapHit       = (gapCnt_d == GW'(GAP_CYC));
    lastEntry    = isLastEntry(tblIdx_q, N_ENTRIES);
    masterIdle   = !i_flag_w && !i_flag_r;
  end

  // Main sequencer. Every output is a register written here, so nothing the
  // master sees can glitch, and address/data only change in LOAD while
  // o_en_I2C is low. The timeout counter also runs in the issue states so a
  // master stuck with a stale done flag cannot hang the walk.
  always_ff @(posedge clock_100Khz) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      enI2c_q      <= 1'b0;
      wrEn_q       <= I2C_WRITE;
      addrReg_q    <= 8'h00;
      dataWr_q     <= 8'h00;
      tblIdx_q     <= 8'h00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      errIdx_q     <= 8'h00;
      timeoutCnt_q <= '0;
      gapCnt_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            tblIdx_q <= 8'h00;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          addrReg_q    <= i_tbl_reg;
          dataWr_q     <= i_tbl_data;
          timeoutCnt_q <= '0;
          state_q      <= ST_ISSUE;
        end

        ST_ISSUE: begin
          if (masterIdle) begin
            wrEn_q       <= I2C_WRITE;
            enI2c_q      <= 1'b1;
            timeoutCnt_q <= '0;
            state_q      <= ST_WAIT_W;
          end else if (timeoutHit) begin
            state_q <= ST_ERROR;
          end else begin
            timeoutCnt_q <= timeoutCnt_d;
          end
        end

        ST_WAIT_W: begin
          if (i_flag_w) begin
            enI2c_q  <= 1'b0;
            gapCnt_q <= '0;
            state_q  <= ST_GAP;
          end else if (timeoutHit) begin
            state_q <= ST_ERROR;
          end else begin
            timeoutCnt_q <= timeoutCnt_d;
          end
        end

        ST_GAP: begin
          if (gapHit) begin
            gapCnt_q <= '0;
`ifdef I2C_READBACK_EN
            timeoutCnt_q <= '0;
            state_q      <= ST_ISSUE_R;
`else
            if (lastEntry) begin
              state_q <= ST_DONE;
            end else begin
              tblIdx_q <= tblIdx_q + 8'd1;
              state_q  <= ST_LOAD;
            end
`endif
          end else begin
            gapCnt_q <= gapCnt_d;
          end
        end

`ifdef I2C_READBACK_EN
        ST_ISSUE_R: begin
          if (masterIdle) begin
            wrEn_q       <= I2C_READ;
            enI2c_q      <= 1'b1;
            timeoutCnt_q <= '0;
            state_q      <= ST_WAIT_R;
          end else if (timeoutHit) begin
            state_q <= ST_ERROR;
          end else begin
            timeoutCnt_q <= timeoutCnt_d;
          end
        end

        // A mismatch goes straight to ERROR with the current index still
        // held, which is what o_err_idx reports.
        ST_WAIT_R: begin
          if (i_flag_r) begin
            enI2c_q <= 1'b0;
            if (i_data_read != dataWr_q) begin
              state_q <= ST_ERROR;
            end else begin
              gapCnt_q <= '0;
              state_q  <= ST_GAP_R;
            end
          end else if (timeoutHit) begin
            state_q <= ST_ERROR;
          end else begin
            timeoutCnt_q <= timeoutCnt_d;
          end
        end

        ST_GAP_R: begin
          if (gapHit) begin
            gapCnt_q <= '0;
            if (lastEntry) begin
              state_q <= ST_DONE;
            end else begin
              tblIdx_q <= tblIdx_q + 8'd1;
              state_q  <= ST_LOAD;
            end
          end else begin
            gapCnt_q <= gapCnt_d;
          end
        end
`endif

        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        ST_ERROR: begin
          enI2c_q  <= 1'b0;
          error_q  <= 1'b1;
          errIdx_q <= tblIdx_q;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_tbl_idx  = tblIdx_q;
  assign o_addr_ic  = ADDR_IC;
  assign o_addr_reg = addrReg_q;
  assign o_data_wr  = dataWr_q;
  assign o_wr_en    = wrEn_q;
  assign o_en_I2C   = enI2c_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_error    = error_q;
  assign o_err_idx  = errIdx_q;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// ----------------------------------------------------------------------------
// tb_i2c_init_sequencer
// Drives i2c_init_sequencer (3-entry table, 20-cycle timeout) together with
// the init ROM and a behavioural I2C master that answers each transaction
// after a random latency. Expected write traffic comes from the bench's own
// copy of the first three table entries.
// ----------------------------------------------------------------------------
module tb_i2c_init_sequencer;

  localparam int N_ENT   = 3;
  localparam int TIMEOUT = 20;

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] tblIdx;
  logic [7:0] tblReg;
  logic [7:0] tblData;
  logic [6:0] addrIc;
  logic [7:0] addrReg;
  logic [7:0] dataWr;
  logic       wrEn;
  logic       enI2c;
  logic       flagW;
  logic       flagR;
  logic [7:0] dataRead;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] errIdx;

  int checks = 0;
  int errors = 0;

  // Expected table contents for the entries this bench walks.
  logic [7:0] expReg  [N_ENT] = '{8'h6B, 8'h1A, 8'h1B};
  logic [7:0] expData [N_ENT] = '{8'h00, 8'h03, 8'h5A};

  // Master-model state and controls.
  logic [15:0] writes[$];
  logic [7:0]  mem [256];
  int          stableErr = 0;
  bit          neverRespond = 0;
  bit          staleHold = 0;
  bit          corruptEntry2 = 0;

  i2c_init_rom uRom (
    .i_idx  (tblIdx),
    .o_reg  (tblReg),
    .o_data (tblData)
  );

  i2c_init_sequencer #(
    .N_ENTRIES   (N_ENT),
    .ADDR_IC     (7'h68),
    .TIMEOUT_CYC (TIMEOUT),
    .GAP_CYC     (4)
  ) dut (
    .clock_100Khz (clock),
    .i_reset      (reset),
    .i_start      (start),
    .o_tbl_idx    (tblIdx),
    .i_tbl_reg    (tblReg),
    .i_tbl_data   (tblData),
    .o_addr_ic    (addrIc),
    .o_addr_reg   (addrReg),
    .o_data_wr    (dataWr),
    .o_wr_en      (wrEn),
    .o_en_I2C     (enI2c),
    .i_flag_w     (flagW),
    .i_flag_r     (flagR),
    .i_data_read  (dataRead),
    .o_busy       (busy),
    .o_done       (done),
    .o_error      (error),
    .o_err_idx    (errIdx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural I2C master: latches the request when o_en_I2C rises, checks
  // it stays stable, answers after a random latency and drops its flags once
  // the enable goes away. Writes land in a register file and a log queue.
  initial begin
    logic [7:0] snapReg, snapData;
    logic       snapWr;
    bit         active, responded;
    int         latency, latCnt;
    flagW = 1'b0;
    flagR = 1'b0;
    dataRead = 8'h00;
    active = 0;
    responded = 0;
    latency = 1;
    latCnt = 0;
    snapReg = 8'h00;
    snapData = 8'h00;
    snapWr = 1'b1;
    forever begin
      @(negedge clock);
      if (reset || !enI2c) begin
        if (!staleHold) flagW = 1'b0;
        flagR = 1'b0;
        active = 0;
      end else if (!active) begin
        active = 1;
        responded = 0;
        latCnt = 0;
        latency = $urandom_range(1, 15);
        snapReg = addrReg;
        snapData = dataWr;
        snapWr = wrEn;
        if (addrIc !== 7'h68) stableErr++;
      end else begin
        if (addrReg !== snapReg || dataWr !== snapData || wrEn !== snapWr || addrIc !== 7'h68)
          stableErr++;
        latCnt++;
        if (!neverRespond && !responded && latCnt >= latency) begin
          responded = 1;
          if (snapWr) begin
            flagW = 1'b1;
            mem[snapReg] = snapData;
            writes.push_back({snapReg, snapData});
          end else begin
            flagR = 1'b1;
            dataRead = (corruptEntry2 && snapReg == 8'h1B) ? 8'hA5 : mem[snapReg];
          end
        end
      end
    end
  end

  // Single comparison point: counts every check and reports any failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle start pulse after a random idle delay.
  task automatic applyStimulus();
    repeat ($urandom_range(0, 5)) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_en"}, 32'(enI2c), 0);
    checkOutput({pfx, "_wr_en"}, 32'(wrEn), 1);
    checkOutput({pfx, "_addr_reg"}, 32'(addrReg), 0);
    checkOutput({pfx, "_data_wr"}, 32'(dataWr), 0);
    checkOutput({pfx, "_tbl_idx"}, 32'(tblIdx), 0);
    checkOutput({pfx, "_busy"}, 32'(busy), 0);
    checkOutput({pfx, "_done"}, 32'(done), 0);
    checkOutput({pfx, "_error"}, 32'(error), 0);
    checkOutput({pfx, "_err_idx"}, 32'(errIdx), 0);
  endtask

  task automatic waitEnd(input int budget);
    for (int i = 0; i < budget && !(done || error); i++) @(negedge clock);
  endtask

  task automatic waitEnAtIdx(input logic [7:0] idx, input int budget);
    for (int i = 0; i < budget && !(enI2c && tblIdx == idx); i++) @(negedge clock);
  endtask

  // Compare the master's write log against the expected table walk.
  task automatic checkWalk(input string pfx);
    checkOutput({pfx, "_write_count"}, 32'(writes.size()), N_ENT);
    for (int i = 0; i < N_ENT && i < writes.size(); i++) begin
      checkOutput($sformatf("%s_reg%0d", pfx, i), 32'(writes[i][15:8]), 32'(expReg[i]));
      checkOutput($sformatf("%s_data%0d", pfx, i), 32'(writes[i][7:0]), 32'(expData[i]));
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clock);
    checkResetValues("reset");
    checkOutput("reset_addr_ic", 32'(addrIc), 32'h68);
    reset = 1'b0;
    @(negedge clock);

    // Full walk with random master latency.
    $display("[TB] normal walk");
    writes.delete();
    applyStimulus();
    checkOutput("walk_busy_after_start", 32'(busy), 1);
    waitEnd(600);
    checkOutput("walk_done", 32'(done), 1);
    checkOutput("walk_busy_end", 32'(busy), 0);
    checkOutput("walk_error", 32'(error), 0);
    checkOutput("walk_last_idx", 32'(tblIdx), 2);
    checkOutput("walk_en_low", 32'(enI2c), 0);
    checkWalk("walk");

    // Restart clears done; second start during entry 1 is ignored.
    $display("[TB] start while busy");
    writes.delete();
    applyStimulus();
    checkOutput("restart_done_cleared", 32'(done), 0);
    checkOutput("restart_busy", 32'(busy), 1);
    waitEnAtIdx(8'd1, 200);
    checkOutput("ignored_at_idx1", 32'(tblIdx), 1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checkOutput("ignored_busy", 32'(busy), 1);
    checkOutput("ignored_idx", 32'(tblIdx), 1);
    waitEnd(600);
    checkOutput("ignored_done", 32'(done), 1);
    checkOutput("ignored_last_idx", 32'(tblIdx), 2);
    repeat (10) @(negedge clock);
    checkOutput("ignored_no_rerun", 32'(busy), 0);
    checkWalk("ignored");

    // Master never answers: error exactly 21 cycles after the enable rises.
    $display("[TB] write timeout");
    neverRespond = 1;
    applyStimulus();
    for (int i = 0; i < 20 && !enI2c; i++) @(negedge clock);
    checkOutput("timeout_en_rose", 32'(enI2c), 1);
    repeat (TIMEOUT) @(negedge clock);
    checkOutput("timeout_not_early", 32'(error), 0);
    @(negedge clock);
    checkOutput("timeout_error", 32'(error), 1);
    checkOutput("timeout_err_idx", 32'(errIdx), 0);
    checkOutput("timeout_en", 32'(enI2c), 0);
    checkOutput("timeout_busy", 32'(busy), 0);
    checkOutput("timeout_done", 32'(done), 0);
    neverRespond = 0;
    repeat (3) @(negedge clock);

    // Reset in the middle of entry 1, then a clean restart from index 0.
    $display("[TB] reset mid-transaction");
    applyStimulus();
    checkOutput("midreset_error_cleared", 32'(error), 0);
    waitEnAtIdx(8'd1, 200);
    checkOutput("midreset_en_before", 32'(enI2c), 1);
    reset = 1'b1;
    @(negedge clock);
    checkResetValues("midreset");
    reset = 1'b0;
    @(negedge clock);
    writes.delete();
    applyStimulus();
    waitEnd(600);
    checkOutput("midreset_rerun_done", 32'(done), 1);
    checkWalk("midreset");

    // Stale write flag: no transaction may start until it drops.
    $display("[TB] stale flag");
    writes.delete();
    staleHold = 1;
    flagW = 1'b1;
    applyStimulus();
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checkOutput($sformatf("stale_en_low%0d", i), 32'(enI2c), 0);
    end
    checkOutput("stale_busy", 32'(busy), 1);
    flagW = 1'b0;
    staleHold = 0;
    waitEnd(600);
    checkOutput("stale_done", 32'(done), 1);
    checkOutput("stale_error", 32'(error), 0);
    checkWalk("stale");

`ifdef I2C_READBACK_EN
    // Readback of entry 2 returns A5 instead of 5A.
    $display("[TB] readback mismatch");
    corruptEntry2 = 1;
    applyStimulus();
    waitEnd(800);
    checkOutput("rb_error", 32'(error), 1);
    checkOutput("rb_err_idx", 32'(errIdx), 2);
    checkOutput("rb_done", 32'(done), 0);
    corruptEntry2 = 0;
`endif

    checkOutput("master_stable", 32'(stableErr), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
